data_sram_resp: RTL
===================

# data_sram_resp

Memory-side responder for the core's data SRAM port. It receives the core's `en`/`wen`/`addr`/`wdata` strobes and returns `rdata` with a fixed one-cycle read latency. The store is 65 bits wide: 8 byte lanes plus a tag bit. It sits in the SoC shell opposite the core's data SRAM master, replacing the behavioural memory in simulation and FPGA builds. It adds an optional post-reset clear sweep and a sticky out-of-range error capture.

## Interface
Parameters:
- `BASE`, 32'h8000_0000: byte address of word 0.
- `DEPTH`, 4096: number of 65-bit words (power of two, ≥ 2).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  access strobe from the core.
- `wen`  in  9  write enables: bits [7:0] select byte lanes of wdata[63:0]; bit 8 selects wdata[64].
- `addr`  in  32  byte address.
- `wdata`  in  65  write data.
- `rdata`  out  65  read data, registered.
- `busy`  out  1  high while the clear sweep runs; accesses are ignored.
- `err`  out  1  sticky flag: an out-of-range access occurred.
- `err_addr`  out  32  address of the first out-of-range access.

## Operation
- Word index `idx = (addr - BASE) >> 3`. `addr[2:0]` is ignored.
- In range means `addr >= BASE` and `addr - BASE < DEPTH*8`, using 32-bit unsigned compare with no wrap.
- Read: `en=1`, `wen=0`, in range. `rdata` is loaded with `mem[idx]` at the next edge.
- Write: `en=1`, `wen!=0`, in range. Each enabled lane of `mem[idx]` is updated and other lanes are kept. `rdata` holds its value.
- `en=0`: no access; `rdata` holds.
- Out-of-range access, read or write:
  - Memory is untouched.
  - A read loads `rdata` with 0; a write leaves `rdata` unchanged.
  - If `err=0`, then `err` is set to 1 and `err_addr` is loaded with `addr`.
  - Later out-of-range accesses do not change `err_addr`.
  - `err` clears only on reset.
- State machine with states CLEAR and READY:
  - Reset enters CLEAR when the clear feature is compiled in, otherwise READY.
  - In CLEAR, a counter `ptr` runs from 0 to DEPTH-1 and writes 65'b0 to `mem[ptr]` each cycle.
  - CLEAR goes to READY on the edge that writes `ptr = DEPTH-1`.
  - READY is terminal until the next reset.
- While `busy=1`, all `en` activity is dropped: no memory write, `rdata` holds, no `err` update.
- Read-after-write to the same word in consecutive cycles returns the new data, because the write commits before the read samples.

## Timing
- Reset values: `rdata=0`, `err=0`, `err_addr=0`, `ptr=0`, and `busy` is 1 with the clear feature or 0 without it.
- Read latency: address at edge N, data valid after edge N+1 and held until the next read.
- Write visible to a read issued at the edge after the write.
- The clear sweep lasts exactly DEPTH cycles after reset deassertion. `busy` falls after edge DEPTH, counting the first post-reset edge as 1.
- Reset asserted mid-sweep restarts the sweep from `ptr=0`. Reset asserted mid-read forces `rdata=0` immediately (asynchronous).
- One access per cycle; there is no back-pressure path. The core must not rely on the responder before `busy=0`.

## Configuration
- `DATA_SRAM_CLEAR_EN`
  - Defined: the CLEAR state, `ptr` counter and sweep are built. Memory reads 0 everywhere after the sweep.
  - Undefined: no CLEAR state, `busy` is tied to 0, and memory powers up with undefined contents (X in simulation). Accesses are served from the first edge after reset.

## Test plan
- Reset with `DATA_SRAM_CLEAR_EN`, DEPTH=16 -> `busy=1` for 16 cycles then 0. A read of `BASE+8*15` then returns 65'b0, and reads issued during busy leave `rdata=0`.
- Write `wdata=65'h1_0123_4567_89AB_CDEF`, `wen=9'h1FF` at `BASE+0x40`, then read -> `rdata=65'h1_0123_4567_89AB_CDEF` one cycle later.
- Partial write `wen=9'h003`, `wdata` low half `0xFFFF` over the above word -> read returns `65'h1_0123_4567_89AB_FFFF`. A further write with `wen=9'h100`, `wdata[64]=0` -> `65'h0_0123_4567_89AB_FFFF`.
- Read at `BASE-8`, then write at `BASE+DEPTH*8` -> `rdata=0` after the read, `err=1`, `err_addr=BASE-8`. The second access leaves `err_addr` unchanged and memory unmodified.
- Back-to-back write then read of the same word on consecutive edges -> the read returns the new data. `rdata` holds through idle cycles and through a write-only cycle.
- Assert reset at sweep cycle 5 -> `busy` stays 1 and a full DEPTH-cycle sweep follows. `err` and `rdata` return to 0.

Source files
------------

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder with one-cycle read latency
//
// Memory-side responder for the core's data SRAM port. Storage is DEPTH
// words of 65 bits (8 byte lanes plus a tag bit). Reads return on the edge
// after the request; writes merge enabled lanes into the addressed word.
// Out-of-range accesses are dropped and the first one is captured in a
// sticky error register.
//
// Optional feature macro: DATA_SRAM_CLEAR_EN
//   defined   : post-reset sweep writes zero to every word; busy is high
//               for exactly DEPTH cycles after reset deassertion.
//   undefined : no sweep, busy tied low, memory contents undefined at start.
//
// Ports:
//   clock     in   1   rising-edge clock
//   reset     in   1   asynchronous active-high reset
//   en        in   1   access strobe
//   wen       in   9   lane write enables ([7:0] bytes, [8] tag bit)
//   addr      in  32   byte address
//   wdata     in  65   write data
//   rdata     out 65   registered read data
//   busy      out  1   clear sweep in progress, accesses ignored
//   err       out  1   sticky out-of-range flag
//   err_addr  out 32   address of first out-of-range access

module data_sram_resp #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [8:0]  wen,
  input  logic [31:0] addr,
  input  logic [64:0] wdata,
  output logic [64:0] rdata,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int          AW   = $clog2(DEPTH);
  // Span held in 33 bits so DEPTH*8 cannot wrap the compare.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

  logic [64:0]   mem [DEPTH];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [64:0]   lane_mask;
  logic          access;
  logic          do_read;
  logic          do_write;
  logic          do_oor;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [64:0]   mem_wdata;
  logic [64:0]   mem_wmask;

  assign off      = addr - BASE;
  assign in_range = (addr >= BASE) && ({1'b0, off} < SPAN);
  assign idx      = off[AW+2:3];

  always_comb begin
    lane_mask = '0;
    for (int l = 0; l < 8; l++) begin
      lane_mask[8*l +: 8] = {8{wen[l]}};
    end
    lane_mask[64] = wen[8];
  end

  // Reset gates the access path so nothing reaches memory while held in reset.
  assign access   = en && !busy && !reset;
  assign do_read  = access && in_range && (wen == 9'd0);
  assign do_write = access && in_range && (wen != 9'd0);
  assign do_oor   = access && !in_range;

`ifdef DATA_SRAM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          clr_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        // Leave on the edge that clears the last word.
        if (ptr == AW'(DEPTH - 1)) begin
          state_next = READY;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: state_next = READY;
    endcase
  end

  assign busy = (state == CLEAR);

  always_comb begin
    mem_we    = do_write;
    mem_waddr = idx;
    mem_wdata = wdata;
    mem_wmask = lane_mask;
    if (clr_we && !reset) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = '0;
      mem_wmask = '1;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    mem_we    = do_write;
    mem_waddr = idx;
    mem_wdata = wdata;
    mem_wmask = lane_mask;
  end
`endif

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // Memory is written at the same edge, so a read issued on the following
  // edge already sees the merged word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (do_read) begin
        rdata <= mem[idx];
      end else if (do_oor && (wen == 9'd0)) begin
        rdata <= '0;
      end
      if (do_oor && !err) begin
        err      <= 1'b1;
        err_addr <= addr;
      end
    end
  end

endmodule
